// File: rtl/mem_burst_sequencer_pkg.sv
// Shared structures for the memory burst sequencer: the command record,
// the FSM state encoding and the default burst limits.
package mem_burst_sequencer_pkg;

  localparam int CMD_WIDTH               = 65;
  localparam int APP_LEN_WIDTH           = 5;
  localparam int DEFAULT_MAX_BURST       = 8;
  localparam int DEFAULT_MAX_OUTSTANDING = 32;

  typedef struct packed {
    logic        readNotWrite;
    logic [31:0] address;
    logic [31:0] length;
  } MemoryCommand;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WDATA = 2'd2
  } SeqState;

endpackage

// File: rtl/mem_burst_sequencer.sv
// Splits one word-addressed memory command into aligned bursts, throttling
// reads against the count of words still in flight and streaming write beats.
module mem_burst_sequencer
  import mem_burst_sequencer_pkg::*;
#(
  parameter int max_burst       = DEFAULT_MAX_BURST,
  parameter int max_outstanding = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CMD_WIDTH-1:0]     cmd_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [31:0]              wr_data,
  output logic                     app_cmd_valid,
  input  logic                     app_cmd_ready,
  output logic [31:0]              app_addr,
  output logic [APP_LEN_WIDTH-1:0] app_len,
  output logic                     app_rnw,
  output logic                     app_wdata_valid,
  input  logic                     app_wdata_ready,
  output logic [31:0]              app_wdata,
  input  logic                     rd_beat,
  output logic                     busy,
  output logic [31:0]              burst_count
);

  localparam int          OW         = $clog2(max_outstanding) + 1;
  localparam logic [31:0] BURST_SIZE = 32'(max_burst);
  localparam logic [31:0] BURST_MASK = 32'(max_burst - 1);

  SeqState                  r_state;
  SeqState                  w_nextState;
  logic [31:0]              r_addr;
  logic [31:0]              r_remaining;
  logic                     r_rnw;
  logic [OW-1:0]            r_outstanding;
  logic [APP_LEN_WIDTH-1:0] r_beats;
  logic [31:0]              r_burstCount;

  MemoryCommand             w_cmd;
  logic [31:0]              w_room;
  logic [APP_LEN_WIDTH-1:0] w_burstLen;
  logic [32:0]              w_outPlusLen;
  logic                     w_readOk;
  logic                     w_cmdFire;
  logic                     w_appFire;
  logic                     w_beatFire;
  logic                     w_lastBeat;
  logic [31:0]              w_remainingAfter;
  logic [OW-1:0]            w_outInc;
  logic [OW-1:0]            w_outDec;

  assign w_cmd = cmd_data;

  // Room left before the next aligned max_burst boundary caps every burst.
  assign w_room     = BURST_SIZE - (r_addr & BURST_MASK);
  assign w_burstLen = (r_remaining < w_room) ? r_remaining[APP_LEN_WIDTH-1:0]
                                             : w_room[APP_LEN_WIDTH-1:0];

  assign w_outPlusLen     = 33'(r_outstanding) + 33'(w_burstLen);
  assign w_readOk         = w_outPlusLen <= 33'(max_outstanding);
  assign w_cmdFire        = cmd_valid && cmd_ready;
  assign w_appFire        = app_cmd_valid && app_cmd_ready;
  assign w_beatFire       = app_wdata_valid && app_wdata_ready;
  assign w_lastBeat       = w_beatFire && (r_beats == APP_LEN_WIDTH'(1));
  assign w_remainingAfter = r_remaining - 32'(w_burstLen);
  assign w_outInc         = (w_appFire && r_rnw) ? OW'(w_burstLen) : '0;
  assign w_outDec         = (rd_beat && (r_outstanding != '0)) ? OW'(1) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (w_cmdFire && (w_cmd.length != 32'd0)) w_nextState = ISSUE;
      ISSUE: begin
        if (w_appFire) begin
          if (!r_rnw)                         w_nextState = WDATA;
          else if (w_remainingAfter == 32'd0) w_nextState = IDLE;
        end
      end
      WDATA: begin
        if (w_lastBeat) w_nextState = (w_remainingAfter == 32'd0) ? IDLE : ISSUE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Write beats pass straight through, gated so nothing leaks outside WDATA.
  always_comb begin
    cmd_ready       = (r_state == IDLE);
    busy            = (r_state != IDLE);
    app_cmd_valid   = (r_state == ISSUE) && (!r_rnw || w_readOk);
    wr_ready        = (r_state == WDATA) && app_wdata_ready;
    app_wdata_valid = (r_state == WDATA) && wr_valid;
    app_wdata       = (r_state == WDATA) ? wr_data : 32'd0;
  end

  assign app_addr    = r_addr;
  assign app_len     = w_burstLen;
  assign app_rnw     = r_rnw;
  assign burst_count = r_burstCount;

  // Address and remaining only move once a burst is fully committed,
  // which keeps app_addr/app_len frozen while a burst waits for ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr        <= 32'd0;
      r_remaining   <= 32'd0;
      r_rnw         <= 1'b0;
      r_outstanding <= '0;
      r_beats       <= '0;
      r_burstCount  <= 32'd0;
    end else begin
      if (w_cmdFire) begin
        r_addr      <= w_cmd.address;
        r_remaining <= w_cmd.length;
        r_rnw       <= w_cmd.readNotWrite;
      end
      if (w_appFire) begin
        r_burstCount <= r_burstCount + 32'd1;
        if (r_rnw) begin
          r_addr      <= r_addr + 32'(w_burstLen);
          r_remaining <= w_remainingAfter;
        end else begin
          r_beats <= w_burstLen;
        end
      end
      if (w_beatFire) begin
        r_beats <= r_beats - APP_LEN_WIDTH'(1);
        if (w_lastBeat) begin
          r_addr      <= r_addr + 32'(w_burstLen);
          r_remaining <= w_remainingAfter;
        end
      end
      r_outstanding <= r_outstanding + w_outInc - w_outDec;
    end
  end

endmodule

// File: tb/tb_mem_burst_sequencer.sv
// Directed bench for mem_burst_sequencer: a table of commands with their
// hand-computed burst lists, plus sequences for throttling, stalls and reset.
module tb_mem_burst_sequencer;
  import mem_burst_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [64:0] cmd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        app_cmd_valid;
  logic        app_cmd_ready;
  logic [31:0] app_addr;
  logic [4:0]  app_len;
  logic        app_rnw;
  logic        app_wdata_valid;
  logic        app_wdata_ready;
  logic [31:0] app_wdata;
  logic        rd_beat;
  logic        busy;
  logic [31:0] burst_count;

  logic rdAuto;
  logic rdManual;
  logic beatHs;
  assign rd_beat = rdAuto | rdManual;

  int checks = 0;
  int errors = 0;
  int expBursts = 0;

  logic [31:0] qAddr[$];
  logic [4:0]  qLen[$];
  logic        qRnw[$];
  logic [31:0] qBeat[$];

  typedef struct packed {
    logic            rnw;
    logic [31:0]     addr;
    logic [31:0]     len;
    logic [2:0]      nb;
    logic [2:0][31:0] bAddr;
    logic [2:0][4:0]  bLen;
  } vec_t;

  vec_t vecs[7];

  mem_burst_sequencer #(.max_burst(8), .max_outstanding(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .app_cmd_valid(app_cmd_valid), .app_cmd_ready(app_cmd_ready),
    .app_addr(app_addr), .app_len(app_len), .app_rnw(app_rnw),
    .app_wdata_valid(app_wdata_valid), .app_wdata_ready(app_wdata_ready),
    .app_wdata(app_wdata), .rd_beat(rd_beat), .busy(busy),
    .burst_count(burst_count)
  );

  always #5 clk = ~clk;

  // Handshakes are recorded 2 time units before the rising edge that takes them.
  always begin
    @(negedge clk);
    #3;
    if (!reset) begin
      if (app_cmd_valid && app_cmd_ready) begin
        qAddr.push_back(app_addr);
        qLen.push_back(app_len);
        qRnw.push_back(app_rnw);
      end
      if (app_wdata_valid && app_wdata_ready) begin
        qBeat.push_back(app_wdata);
        beatHs = 1'b1;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (beatHs) begin
      wr_data = wr_data + 32'd1;
      beatHs  = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mkVec(input logic rnw, input logic [31:0] addr, input logic [31:0] len,
                                 input logic [2:0] nb,
                                 input logic [31:0] a0, input logic [4:0] l0,
                                 input logic [31:0] a1, input logic [4:0] l1,
                                 input logic [31:0] a2, input logic [4:0] l2);
    vec_t v;
    v.rnw = rnw; v.addr = addr; v.len = len; v.nb = nb;
    v.bAddr[0] = a0; v.bLen[0] = l0;
    v.bAddr[1] = a1; v.bLen[1] = l1;
    v.bAddr[2] = a2; v.bLen[2] = l2;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearQueues();
    qAddr.delete();
    qLen.delete();
    qRnw.delete();
    qBeat.delete();
    wr_data = 32'd1;
  endtask

  task automatic applyStimulus(input logic rnw, input logic [31:0] addr, input logic [31:0] len);
    cmd_data  = {rnw, addr, len};
    cmd_valid = 1'b1;
    checkOutput("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input bit toggleWready);
    int n = 0;
    while (busy && n < budget) begin
      if (toggleWready) app_wdata_ready = ~app_wdata_ready;
      @(negedge clk);
      n++;
    end
    app_wdata_ready = 1'b1;
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"},       32'(cmd_ready), 32'd1);
    checkOutput({tag, "_app_cmd_valid"},   32'(app_cmd_valid), 32'd0);
    checkOutput({tag, "_app_addr"},        app_addr, 32'd0);
    checkOutput({tag, "_app_len"},         32'(app_len), 32'd0);
    checkOutput({tag, "_app_rnw"},         32'(app_rnw), 32'd0);
    checkOutput({tag, "_wr_ready"},        32'(wr_ready), 32'd0);
    checkOutput({tag, "_app_wdata_valid"}, 32'(app_wdata_valid), 32'd0);
    checkOutput({tag, "_app_wdata"},       app_wdata, 32'd0);
    checkOutput({tag, "_busy"},            32'(busy), 32'd0);
    checkOutput({tag, "_burst_count"},     burst_count, 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = mkVec(1'b1, 32'h10, 32'd20, 3'd3, 32'h10, 5'd8, 32'h18, 5'd8, 32'h20, 5'd4);
    vecs[1] = mkVec(1'b1, 32'h03, 32'd3,  3'd1, 32'h03, 5'd3, 32'h0,  5'd0, 32'h0,  5'd0);
    vecs[2] = mkVec(1'b1, 32'h06, 32'd10, 3'd2, 32'h06, 5'd2, 32'h08, 5'd8, 32'h0,  5'd0);
    vecs[3] = mkVec(1'b1, 32'hFFFFFFFE, 32'd5, 3'd2, 32'hFFFFFFFE, 5'd2, 32'h0, 5'd3, 32'h0, 5'd0);
    vecs[4] = mkVec(1'b0, 32'h05, 32'd6,  3'd2, 32'h05, 5'd3, 32'h08, 5'd3, 32'h0,  5'd0);
    vecs[5] = mkVec(1'b1, 32'h07, 32'd1,  3'd1, 32'h07, 5'd1, 32'h0,  5'd0, 32'h0,  5'd0);
    vecs[6] = mkVec(1'b0, 32'h0F, 32'd9,  3'd2, 32'h0F, 5'd1, 32'h10, 5'd8, 32'h0,  5'd0);

    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0;
    wr_valid = 1'b1; wr_data = 32'd1; beatHs = 1'b0;
    app_cmd_ready = 1'b1; app_wdata_ready = 1'b1;
    rdAuto = 1'b1; rdManual = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      clearQueues();
      applyStimulus(vecs[i].rnw, vecs[i].addr, vecs[i].len);
      waitIdle(200, 1'b0);
      expBursts += int'(vecs[i].nb);
      checkOutput($sformatf("v%0d_num_bursts", i), 32'(qAddr.size()), 32'(vecs[i].nb));
      for (int b = 0; b < int'(vecs[i].nb) && b < qAddr.size(); b++) begin
        checkOutput($sformatf("v%0d_b%0d_addr", i, b), qAddr[b], vecs[i].bAddr[b]);
        checkOutput($sformatf("v%0d_b%0d_len", i, b), 32'(qLen[b]), 32'(vecs[i].bLen[b]));
        checkOutput($sformatf("v%0d_b%0d_rnw", i, b), 32'(qRnw[b]), 32'(vecs[i].rnw));
      end
      if (!vecs[i].rnw) begin
        checkOutput($sformatf("v%0d_num_beats", i), 32'(qBeat.size()), vecs[i].len);
        for (int k = 0; k < qBeat.size(); k++)
          checkOutput($sformatf("v%0d_beat%0d", i, k), qBeat[k], 32'(k + 1));
      end
      checkOutput($sformatf("v%0d_burst_count", i), burst_count, 32'(expBursts));
    end

    // Outstanding limit: 4 bursts of 8 fill the 32-word window.
    repeat (40) @(negedge clk);
    rdAuto = 1'b0;
    clearQueues();
    applyStimulus(1'b1, 32'h0, 32'd64);
    repeat (30) @(negedge clk);
    checkOutput("throttle_num_bursts", 32'(qAddr.size()), 32'd4);
    checkOutput("throttle_valid_low", 32'(app_cmd_valid), 32'd0);
    checkOutput("throttle_addr", app_addr, 32'h20);
    checkOutput("throttle_len", 32'(app_len), 32'd8);
    checkOutput("throttle_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 7; k++) begin
      rdManual = 1'b1;
      @(negedge clk);
    end
    rdManual = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("throttle_after7_bursts", 32'(qAddr.size()), 32'd4);
    rdManual = 1'b1;
    @(negedge clk);
    rdManual = 1'b0;
    @(negedge clk);
    checkOutput("throttle_after8_bursts", 32'(qAddr.size()), 32'd5);
    if (qAddr.size() >= 5) checkOutput("throttle_b4_addr", qAddr[4], 32'h20);
    rdAuto = 1'b1;
    waitIdle(400, 1'b0);
    expBursts += 8;
    checkOutput("throttle_total_bursts", 32'(qAddr.size()), 32'd8);
    checkOutput("throttle_burst_count", burst_count, 32'(expBursts));

    // Zero-length command is swallowed without a burst.
    repeat (40) @(negedge clk);
    clearQueues();
    applyStimulus(1'b1, 32'h55, 32'd0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("zero_busy_c%0d", k), 32'(busy), 32'd0);
      checkOutput($sformatf("zero_valid_c%0d", k), 32'(app_cmd_valid), 32'd0);
      @(negedge clk);
    end
    checkOutput("zero_burst_count", burst_count, 32'(expBursts));
    checkOutput("zero_cmd_ready", 32'(cmd_ready), 32'd1);

    // Command stall: burst fields must hold while app_cmd_ready is low.
    clearQueues();
    app_cmd_ready = 1'b0;
    applyStimulus(1'b1, 32'h40, 32'd8);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall_valid_c%0d", k), 32'(app_cmd_valid), 32'd1);
      checkOutput($sformatf("stall_addr_c%0d", k), app_addr, 32'h40);
      checkOutput($sformatf("stall_len_c%0d", k), 32'(app_len), 32'd8);
      @(negedge clk);
    end
    app_cmd_ready = 1'b1;
    waitIdle(100, 1'b0);
    expBursts += 1;
    checkOutput("stall_num_bursts", 32'(qAddr.size()), 32'd1);

    // Toggling app_wdata_ready must neither drop nor repeat beats.
    clearQueues();
    applyStimulus(1'b0, 32'h100, 32'd8);
    waitIdle(200, 1'b1);
    expBursts += 1;
    checkOutput("toggle_num_beats", 32'(qBeat.size()), 32'd8);
    for (int k = 0; k < qBeat.size(); k++)
      checkOutput($sformatf("toggle_beat%0d", k), qBeat[k], 32'(k + 1));
    checkOutput("toggle_burst_count", burst_count, 32'(expBursts));

    // Reset after two of eight write beats abandons the command.
    clearQueues();
    applyStimulus(1'b0, 32'h200, 32'd8);
    n = 0;
    while (qBeat.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midreset_beats_before", 32'(qBeat.size()), 32'd2);
    reset = 1'b1;
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midreset_no_more_beats", 32'(qBeat.size()), 32'd2);
    checkOutput("midreset_no_more_bursts", 32'(qAddr.size()), 32'd1);
    checkOutput("midreset_idle", 32'(busy), 32'd0);
    expBursts = 0;
    clearQueues();
    applyStimulus(1'b1, 32'h08, 32'd4);
    waitIdle(100, 1'b0);
    checkOutput("post_reset_num_bursts", 32'(qAddr.size()), 32'd1);
    if (qAddr.size() >= 1) begin
      checkOutput("post_reset_addr", qAddr[0], 32'h08);
      checkOutput("post_reset_len", 32'(qLen[0]), 32'd4);
    end
    checkOutput("post_reset_burst_count", burst_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_sequencer.md
MEM_BURST_SEQUENCER -- requirements
Module: mem_burst_sequencer

Interface
REQ-001 SHALL have parameter max_burst, default 8, the maximum words per memory burst (power of two, 2..16).
REQ-002 SHALL have parameter max_outstanding, default 32, the maximum read words requested but not yet returned.
REQ-003 clk  input  1  sole clock, memory domain; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  command handshake, transfer when both high.
REQ-006 cmd_data  input  65  MemoryCommand: read_not_write, address[31:0], length[31:0] in words.
REQ-007 wr_valid / wr_ready / wr_data  input / output / input  1 / 1 / 32  write-data stream from the arbiter.
REQ-008 app_cmd_valid / app_cmd_ready  output / input  1 / 1  burst command handshake to the memory controller.
REQ-009 app_addr / app_len / app_rnw  output  32 / 5 / 1  burst word address, burst length 1..max_burst, 1 = read.
REQ-010 app_wdata_valid / app_wdata_ready / app_wdata  output / input / output  1 / 1 / 32  write beats to the memory controller.
REQ-011 rd_beat  input  1  one read word returned by the memory controller this cycle.
REQ-012 busy  output  1  high when the state is not IDLE.
REQ-013 burst_count  output  32  total bursts accepted on app_cmd since reset, wraps at 2^32.

Function
REQ-014 SHALL use states IDLE, ISSUE, WDATA.
REQ-015 IDLE: cmd_ready=1. On handshake, latch addr, remaining=length, rnw. Length 0: stay IDLE with no burst. Otherwise go to ISSUE.
REQ-016 Burst length SHALL be min(remaining, max_burst - (addr mod max_burst)), so no burst crosses an aligned max_burst boundary.
REQ-017 ISSUE: app_cmd_valid=1 with app_addr=addr, app_len=burst length, app_rnw=rnw. For reads, this requires outstanding + burst length <= max_outstanding.
REQ-018 Once app_cmd_valid is asserted, app_addr, app_len and app_rnw SHALL hold stable until app_cmd_ready.
REQ-019 Read burst accepted: addr += len, remaining -= len, outstanding += len. Go to IDLE if remaining reaches 0, else stay in ISSUE.
REQ-020 Write burst accepted: load beat counter with len and go to WDATA.
REQ-021 WDATA: app_wdata_valid=wr_valid, wr_ready=app_wdata_ready, app_wdata=wr_data, all combinational. Each handshake decrements the beat counter.
REQ-022 Last write beat: addr += len, remaining -= len. Go to IDLE if remaining is 0, else ISSUE.
REQ-023 Outside WDATA, wr_ready=0 and app_wdata_valid=0.
REQ-024 outstanding (width clog2(max_outstanding)+1) SHALL change by +len on read accept and -1 on rd_beat. Both in one cycle give the net change.
REQ-025 rd_beat with outstanding=0 SHALL be ignored (no underflow).
REQ-026 Address arithmetic SHALL be 32-bit modulo; wrap past 0xFFFFFFFF is allowed.
REQ-027 A new command SHALL NOT be accepted until the previous one completes (one command in flight); read returns MAY still be pending.

Reset
REQ-028 On reset: state=IDLE, cmd_ready=1, app_cmd_valid=0, app_addr=0, app_len=0, app_rnw=0, wr_ready=0, app_wdata_valid=0, app_wdata=0, busy=0, burst_count=0, outstanding=0, beat counter=0.
REQ-029 Reset mid-command SHALL abandon the command. No further bursts or beats are issued, and partially written bursts are not completed.

Structure
REQ-030 MemoryCommand and the burst constants SHALL live in the shared structures package; command width is 65 bits.
REQ-031 SHALL be a single module with no sub-modules; burst-length computation is inline combinational logic.

Verification
REQ-032 Read, addr 0x10, length 20, max_burst 8, app_cmd_ready=1 -> bursts (0x10,8), (0x18,8), (0x20,4), then IDLE.
REQ-033 Write, addr 0x05, length 6, streaming data 1..6 -> bursts (0x05,3) beats 1,2,3 and (0x08,3) beats 4,5,6; burst_count=2.
REQ-034 Read, length 64, max_outstanding 32, no rd_beat -> exactly 4 bursts of 8 issued, then app_cmd_valid held with (0x20,8). 8 rd_beat pulses -> next burst issues.
REQ-035 Length 0 command -> cmd accepted in 1 cycle, no app_cmd_valid, busy stays 0.
REQ-036 app_cmd_ready held low 5 cycles -> app_addr/app_len stable throughout; app_wdata_ready toggling -> beats not lost or duplicated.
REQ-037 Reset asserted during WDATA after 2 of 8 beats -> all outputs at reset values; next command starts cleanly.
